des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Consumes the 56-bit PC-1-permuted key from the key-check stage and generates the 16 DES 48-bit round keys K1..K16, one per accepted handshake.
- Supports encrypt order (K1 first) and decrypt order (K16 first).
- Feeds the round-function datapath, which applies backpressure through a valid/ready handshake.

Parameters:
- None. DES widths and the schedule are fixed by FIPS 46-3.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous, active-low reset
- key_in  input  56  PC-1 output; key_in[55] = PC-1 bit 1; C = key_in[55:28], D = key_in[27:0]
- key_valid_in  input  1  one-cycle pulse; key_in is valid
- key_err_in  input  1  parity error from the upstream key check
- decrypt_in  input  1  sampled with key_valid_in; 1 = reverse order
- round_key_out  output  48  PC-2 result; [47] = PC-2 bit 1
- round_idx_out  output  4  index of the presented key, minus 1 (K1 = 0, K16 = 15)
- round_key_valid_out  output  1  round_key_out is valid
- round_key_ready_in  input  1  downstream accepts the key
- busy_out  output  1  generation in progress
- done_out  output  1  one-cycle pulse after the last key is transferred
- key_err_out  output  1  one-cycle pulse when a key or run is aborted by key_err_in

Behaviour:
- Reset: state IDLE; all outputs 0; CD register 0; round counter 0.
- FSM states: IDLE, GEN.
  - IDLE -> GEN on key_valid_in & !key_err_in.
  - GEN -> IDLE on the transfer of the 16th key, or on key_err_in.
- Accept edge (key_valid_in high):
  - Latch decrypt mode.
  - Encrypt: CD <= {rotl(C, s1), rotl(D, s1)}.
  - Decrypt: CD <= key_in unrotated, since CD16 = CD0.
  - Register round_key_out <= PC2(new CD) and round_key_valid_out <= 1, so valid is visible the cycle after the accept edge.
  - round_idx_out = 0 (encrypt) or 15 (decrypt); busy_out <= 1.
- Shift schedule s1..s16 = 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1.
- Each rotation acts independently on the 28-bit C and D halves and wraps around within each half.
- Advance on round_key_valid_out & round_key_ready_in, with round number r = the index of the key just transferred:
  - Encrypt: CD <= rotl(CD, s[r+1]); idx + 1.
  - Decrypt: CD <= rotr(CD, s[r]); idx - 1.
  - The next key is registered the same edge, giving zero bubbles: 16 keys in 16 cycles with ready held high.
- Stall: while valid & !ready, round_key_out, round_idx_out and the CD register hold stable.
- Completion: on the 16th transfer, valid <= 0, busy <= 0, done_out pulses for one cycle, return to IDLE. The CD register holds its final value.
- PC-2 maps output bits 1..48 from CD bits (1 = CD[55]):
  - 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4
  - 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40
  - 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32
- key_err_in high (any state):
  - Abort: valid <= 0, busy <= 0, key_err_out pulses, state IDLE.
  - key_err_in takes priority over a simultaneous key_valid_in.
- key_valid_in during GEN:
  - Restart with the new key exactly as for an accept edge in IDLE. The upstream stage cannot stall, so the new key must be captured.
  - A transfer occurring on the same edge is discarded and done_out does not pulse.
- Reset mid-run: immediate return to the reset state.
- round_key_ready_in is ignored while round_key_valid_out is low.

Test Plan:
- Encrypt, ready tied high, key_in = 56'hF0CCAAF556678F (key 133457799BBCDFF1) -> K1 = 48'h1B02EFFC7072, K2 = 48'h79AED9DBC9E5, K16 = 48'hCB3D8B0E17F5; idx 0..15 on consecutive cycles; done_out pulses one cycle after K16.
- Same key, decrypt_in = 1 -> first key 48'hCB3D8B0E17F5 with idx 15, then K15..K1 in order; last key 48'h1B02EFFC7072 with idx 0.
- Encrypt with ready deasserted for 3 cycles after K2 is presented -> K2 and idx 1 held stable for 3 cycles, then K3 follows; total 19 cycles from first valid to done.
- key_valid_in together with key_err_in in IDLE -> no valid, key_err_out pulses once, busy stays 0. key_err_in during round 5 -> valid drops next cycle, no done_out.
- New key_valid_in during round 8 of a run -> next presented key is K1 of the new key, idx 0; the old run produces no done_out.
- Assert rst_n_in low during round 10 -> all outputs 0 immediately; next key starts cleanly with K1.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES round-key generator: turns a PC-1 key into K1..K16 (or K16..K1) over a
// valid/ready stream, one key per transfer with no bubbles.
module des_key_schedule (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [55:0] key_in,
  input  logic        key_valid_in,
  input  logic        key_err_in,
  input  logic        decrypt_in,
  output logic [47:0] round_key_out,
  output logic [3:0]  round_idx_out,
  output logic        round_key_valid_out,
  input  logic        round_key_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        key_err_out
);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  // PC-2 source positions, 1 = CD[55]
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_p0, state_nxt;
  logic [55:0] cd_p0, cd_nxt;
  logic        dec_p0, dec_nxt;
  logic [47:0] key_nxt;
  logic [3:0]  idx_nxt;
  logic        vld_nxt, busy_nxt, done_nxt, err_nxt;

  logic        xfer, last_key;
  logic [55:0] cd_accept, cd_advance;

  // True when round r (0-based) uses a two-bit rotation
  function automatic logic shift_two(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic two);
    return {rotl28(cd[55:28], two), rotl28(cd[27:0], two)};
  endfunction

  function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
    return {rotr28(cd[55:28], two), rotr28(cd[27:0], two)};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    logic [5:0]  src;
    logic [5:0]  dst;
    o = '0;
    for (int i = 0; i < 48; i++) begin
      src    = 6'(56 - PC2_TAB[i]);
      dst    = 6'(47 - i);
      o[dst] = cd[src];
    end
    return o;
  endfunction

  // Decrypt starts from CD16, which equals CD0 since the shifts total 28
  assign cd_accept  = decrypt_in ? key_in : rotl_cd(key_in, 1'b0);
  assign cd_advance = dec_p0 ? rotr_cd(cd_p0, shift_two(round_idx_out))
                             : rotl_cd(cd_p0, shift_two(round_idx_out + 4'd1));
  assign xfer       = round_key_valid_out & round_key_ready_in;
  assign last_key   = dec_p0 ? (round_idx_out == 4'd0) : (round_idx_out == 4'd15);

  always_comb begin
    state_nxt = state_p0;
    cd_nxt    = cd_p0;
    dec_nxt   = dec_p0;
    key_nxt   = round_key_out;
    idx_nxt   = round_idx_out;
    vld_nxt   = round_key_valid_out;
    busy_nxt  = busy_out;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (key_err_in) begin
      state_nxt = IDLE;
      vld_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      err_nxt   = 1'b1;
    end else if (key_valid_in) begin
      // A new key always wins over a transfer on the same edge
      state_nxt = GEN;
      dec_nxt   = decrypt_in;
      cd_nxt    = cd_accept;
      key_nxt   = pc2(cd_accept);
      idx_nxt   = decrypt_in ? 4'd15 : 4'd0;
      vld_nxt   = 1'b1;
      busy_nxt  = 1'b1;
    end else if (state_p0 == GEN && xfer) begin
      if (last_key) begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end else begin
        cd_nxt  = cd_advance;
        key_nxt = pc2(cd_advance);
        idx_nxt = dec_p0 ? round_idx_out - 4'd1 : round_idx_out + 4'd1;
      end
    end
  end

  // Output/state register stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_p0            <= IDLE;
      cd_p0               <= '0;
      dec_p0              <= 1'b0;
      round_key_out       <= '0;
      round_idx_out       <= '0;
      round_key_valid_out <= 1'b0;
      busy_out            <= 1'b0;
      done_out            <= 1'b0;
      key_err_out         <= 1'b0;
    end else begin
      state_p0            <= state_nxt;
      cd_p0               <= cd_nxt;
      dec_p0              <= dec_nxt;
      round_key_out       <= key_nxt;
      round_idx_out       <= idx_nxt;
      round_key_valid_out <= vld_nxt;
      busy_out            <= busy_nxt;
      done_out            <= done_nxt;
      key_err_out         <= err_nxt;
    end
  end

endmodule
